// File: rtl/cdu_rc_sequencer_pkg.sv
// rtl/cdu_rc_sequencer_pkg.sv - shared types and defaults for the CDU read-counter sequencer
// Contents: mode state enum, pulse-direction codes, default parameter values.
package cdu_pkg;

  typedef enum logic [1:0] {
    ST_ZERO   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2
  } cdu_state_e;

  // Direction of the pulse chosen for the current slot.
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_P    = 2'b01;
  localparam logic [1:0] DIR_M    = 2'b10;

  localparam int PEND_W_DEF       = 6;
  localparam int PULSE_DIV_DEF    = 4;
  localparam int COARSE_DWELL_DEF = 16;
  localparam int FINE_HOLD_DEF    = 8;

endpackage

// File: rtl/cdu_rc_sequencer_if.sv
// rtl/cdu_rc_sequencer_if.sv - channel-side signal bundle of the CDU read-counter sequencer
// master: drives tick, AGC moding, comparator status and increment requests; observes results.
// slave : the sequencer; drives rc_clear, mode_coarse, mode_fine, pulse_p, pulse_m, pend, busy.
// Optional macro CDU_RC_OVF_EN adds the sticky ovf flag.
interface cdu_rc_sequencer_if #(
  parameter int PEND_W = cdu_pkg::PEND_W_DEF
);
  logic              tick;
  logic              agc_zero;
  logic              agc_coarse;
  logic              coarse_big;
  logic              fine_null;
  logic              inc_up;
  logic              inc_dn;
  logic              rc_clear;
  logic              mode_coarse;
  logic              mode_fine;
  logic              pulse_p;
  logic              pulse_m;
  logic [PEND_W-1:0] pend;
  logic              busy;
`ifdef CDU_RC_OVF_EN
  logic              ovf;

  modport master (
    output tick, agc_zero, agc_coarse, coarse_big, fine_null, inc_up, inc_dn,
    input  rc_clear, mode_coarse, mode_fine, pulse_p, pulse_m, pend, busy, ovf
  );
  modport slave (
    input  tick, agc_zero, agc_coarse, coarse_big, fine_null, inc_up, inc_dn,
    output rc_clear, mode_coarse, mode_fine, pulse_p, pulse_m, pend, busy, ovf
  );
`else
  modport master (
    output tick, agc_zero, agc_coarse, coarse_big, fine_null, inc_up, inc_dn,
    input  rc_clear, mode_coarse, mode_fine, pulse_p, pulse_m, pend, busy
  );
  modport slave (
    input  tick, agc_zero, agc_coarse, coarse_big, fine_null, inc_up, inc_dn,
    output rc_clear, mode_coarse, mode_fine, pulse_p, pulse_m, pend, busy
  );
`endif
endinterface

// File: rtl/cdu_rc_sequencer_pacer.sv
// rtl/cdu_rc_sequencer_pacer.sv - signed increment backlog and rate-limited AGC pulse generator
// Ports: clk, rst (sync active-high), tick, zero_req (clear/hold backlog), suppress (hold pulses),
//        inc_up/inc_dn (requests), pulse_p/pulse_m (one-clk pulses), pend (backlog), busy (pend != 0),
//        ovf (sticky saturation-drop flag, only with CDU_RC_OVF_EN).
module cdu_pulse_pacer
  import cdu_pkg::*;
#(
  parameter int PEND_W    = PEND_W_DEF,
  parameter int PULSE_DIV = PULSE_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              zero_req,
  input  logic              suppress,
  input  logic              inc_up,
  input  logic              inc_dn,
  output logic              pulse_p,
  output logic              pulse_m,
  output logic [PEND_W-1:0] pend,
`ifdef CDU_RC_OVF_EN
  output logic              ovf,
`endif
  output logic              busy
);

  localparam int SC_W = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = {1'b0, {(PEND_W-1){1'b1}}};
  localparam logic [PEND_W-1:0] PEND_MIN = {1'b1, {(PEND_W-1){1'b0}}};
  localparam logic [SC_W-1:0]   SLOT_LAST = SC_W'(PULSE_DIV - 1);

  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_req;
  logic [PEND_W-1:0] pend_nxt;
  logic [SC_W-1:0]   slot_cnt;
  logic              slot;
  logic [1:0]        dir_nxt;

  always_comb begin
    // Request update first; simultaneous up/dn cancel, saturation drops the request.
    pend_req = pend_q;
    if (inc_up && !inc_dn && pend_q != PEND_MAX) begin
      pend_req = pend_q + PEND_W'(1);
    end else if (inc_dn && !inc_up && pend_q != PEND_MIN) begin
      pend_req = pend_q - PEND_W'(1);
    end

    // The sign test sees this cycle's request, so a slot-cycle request can pulse at once.
    slot    = tick && (slot_cnt == SLOT_LAST);
    dir_nxt = DIR_NONE;
    if (slot && !suppress && !zero_req) begin
      if (pend_req[PEND_W-1]) begin
        dir_nxt = DIR_M;
      end else if (pend_req != '0) begin
        dir_nxt = DIR_P;
      end
    end

    pend_nxt = pend_req;
    if (dir_nxt == DIR_P) begin
      pend_nxt = pend_req - PEND_W'(1);
    end else if (dir_nxt == DIR_M) begin
      pend_nxt = pend_req + PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      slot_cnt <= '0;
      pulse_p  <= 1'b0;
      pulse_m  <= 1'b0;
    end else begin
      // Slot phase is held at 0 while zeroed so the first slot after release is PULSE_DIV ticks out.
      if (zero_req) begin
        slot_cnt <= '0;
      end else if (tick) begin
        slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + SC_W'(1);
      end
      pend_q  <= zero_req ? '0 : pend_nxt;
      pulse_p <= (dir_nxt == DIR_P);
      pulse_m <= (dir_nxt == DIR_M);
    end
  end

`ifdef CDU_RC_OVF_EN
  always_ff @(posedge clk) begin
    if (rst || zero_req) begin
      ovf <= 1'b0;
    end else if ((inc_up && !inc_dn && pend_q == PEND_MAX) ||
                 (inc_dn && !inc_up && pend_q == PEND_MIN)) begin
      ovf <= 1'b1;
    end
  end
`endif

  assign pend = pend_q;
  assign busy = (pend_q != '0);

endmodule

// File: rtl/cdu_rc_sequencer.sv
// rtl/cdu_rc_sequencer.sv - ZERO/COARSE/FINE mode sequencer for one CDU read-counter channel
// Ports: clk, rst (sync active-high), bus (cdu_rc_sequencer_if.slave: tick, agc_zero, agc_coarse,
//        coarse_big, fine_null, inc_up, inc_dn in; rc_clear, mode_coarse, mode_fine, pulse_p,
//        pulse_m, pend, busy out). Optional macro CDU_RC_OVF_EN adds bus.ovf.
module cdu_rc_sequencer
  import cdu_pkg::*;
#(
  parameter int PEND_W       = PEND_W_DEF,
  parameter int PULSE_DIV    = PULSE_DIV_DEF,
  parameter int COARSE_DWELL = COARSE_DWELL_DEF,
  parameter int FINE_HOLD    = FINE_HOLD_DEF
) (
  input logic               clk,
  input logic               rst,
  cdu_rc_sequencer_if.slave bus
);

  localparam int DW_W = $clog2(COARSE_DWELL + 1);
  localparam int NH_W = $clog2(FINE_HOLD + 1);
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(COARSE_DWELL);
  localparam logic [NH_W-1:0] HOLD_MAX  = NH_W'(FINE_HOLD);

  cdu_state_e      state;
  logic [DW_W-1:0] dwell_cnt;
  logic [NH_W-1:0] null_cnt;
  logic [DW_W-1:0] dwell_inc;
  logic [NH_W-1:0] null_inc;
  logic            rc_clear_q;
  logic            mode_coarse_q;
  logic            mode_fine_q;
  logic            zero_req;

  // Both counters saturate so a long COARSE stay cannot wrap them back below threshold.
  always_comb begin
    dwell_inc = (dwell_cnt == DWELL_MAX) ? dwell_cnt : dwell_cnt + DW_W'(1);
    null_inc  = '0;
    if (bus.fine_null) begin
      null_inc = (null_cnt == HOLD_MAX) ? null_cnt : null_cnt + NH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ZERO;
      dwell_cnt     <= '0;
      null_cnt      <= '0;
      rc_clear_q    <= 1'b1;
      mode_coarse_q <= 1'b0;
      mode_fine_q   <= 1'b0;
    end else if (bus.tick) begin
      if (bus.agc_zero) begin
        state         <= ST_ZERO;
        dwell_cnt     <= '0;
        null_cnt      <= '0;
        rc_clear_q    <= 1'b1;
        mode_coarse_q <= 1'b0;
        mode_fine_q   <= 1'b0;
      end else begin
        case (state)
          ST_ZERO: begin
            state         <= ST_COARSE;
            rc_clear_q    <= 1'b0;
            mode_coarse_q <= 1'b1;
            mode_fine_q   <= 1'b0;
          end
          ST_COARSE: begin
            dwell_cnt <= dwell_inc;
            null_cnt  <= null_inc;
            if (dwell_inc == DWELL_MAX && null_inc == HOLD_MAX && !bus.agc_coarse) begin
              state         <= ST_FINE;
              mode_coarse_q <= 1'b0;
              mode_fine_q   <= 1'b1;
            end
          end
          ST_FINE: begin
            if (bus.coarse_big || bus.agc_coarse) begin
              state         <= ST_COARSE;
              dwell_cnt     <= '0;
              null_cnt      <= '0;
              mode_coarse_q <= 1'b1;
              mode_fine_q   <= 1'b0;
            end
          end
          default: begin
            state         <= ST_ZERO;
            dwell_cnt     <= '0;
            null_cnt      <= '0;
            rc_clear_q    <= 1'b1;
            mode_coarse_q <= 1'b0;
            mode_fine_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Include the deciding agc_zero tick so the backlog clears and pulses stop on that same edge.
  assign zero_req = (state == ST_ZERO) || (bus.tick && bus.agc_zero);

  assign bus.rc_clear    = rc_clear_q;
  assign bus.mode_coarse = mode_coarse_q;
  assign bus.mode_fine   = mode_fine_q;

  cdu_pulse_pacer #(
    .PEND_W    (PEND_W),
    .PULSE_DIV (PULSE_DIV)
  ) u_pacer (
    .clk      (clk),
    .rst      (rst),
    .tick     (bus.tick),
    .zero_req (zero_req),
    .suppress (bus.agc_coarse),
    .inc_up   (bus.inc_up),
    .inc_dn   (bus.inc_dn),
    .pulse_p  (bus.pulse_p),
    .pulse_m  (bus.pulse_m),
    .pend     (bus.pend),
`ifdef CDU_RC_OVF_EN
    .ovf      (bus.ovf),
`endif
    .busy     (bus.busy)
  );

endmodule
